// File: rtl/game_ctrl_if.sv
// game_ctrl_if: bundles the game controller's player/enemy inputs and its
// state/spawn/score outputs.
//   keycode      - three packed USB keycodes, [7:0] [15:8] [23:16]; bit 24 unused
//   Ball_die     - player collision flag
//   enemy_alive  - per-slot enemy occupancy
//   game_state   - 0=IDLE 1=PLAY 2=DYING 3=OVER
//   spawn_req    - one-hot, one-cycle spawn command per slot
//   spawn_x      - X position for the enemy being spawned
//   ball_reset   - one-cycle player re-centre pulse
//   freeze       - high whenever the game is not in PLAY
//   lives        - remaining lives
//   score        - frames survived in the current game
// master: drives the inputs (game top / testbench); slave: the controller.
interface game_ctrl_if;
  logic [24:0] keycode;
  logic        Ball_die;
  logic        enemy_alive [4];
  logic [1:0]  game_state;
  logic [3:0]  spawn_req;
  logic [9:0]  spawn_x;
  logic        ball_reset;
  logic        freeze;
  logic [1:0]  lives;
  logic [15:0] score;

  modport master (
    output keycode, Ball_die, enemy_alive,
    input  game_state, spawn_req, spawn_x, ball_reset, freeze, lives, score
  );

  modport slave (
    input  keycode, Ball_die, enemy_alive,
    output game_state, spawn_req, spawn_x, ball_reset, freeze, lives, score
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: frame-rate game sequencer. Handles start/death/game-over flow,
// lives, score, and round-robin enemy spawning with a pseudo-random X.
// Ports:
//   frame_clk - one rising edge per video frame
//   Reset     - asynchronous, active-high
//   bus       - game_ctrl_if.slave (see interface header for signal list)
//
// state | meaning
// IDLE  | waiting for a start key press
// PLAY  | game running: score counts, spawn timer runs, collisions watched
// DYING | death freeze lasting DIE_HOLD frames
// OVER  | out of lives; start returns to IDLE
module game_ctrl #(
  parameter int SPAWN_PERIOD = 60,
  parameter int DIE_HOLD     = 90,
  parameter int LIVES_INIT   = 3
) (
  input logic        frame_clk,
  input logic        Reset,
  game_ctrl_if.slave bus
);

  localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int HOLD_W  = (DIE_HOLD > 1) ? $clog2(DIE_HOLD) : 1;
  localparam logic [SPAWN_W-1:0] SPAWN_TC   = SPAWN_W'(SPAWN_PERIOD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_TC    = HOLD_W'(DIE_HOLD - 1);
  localparam logic [15:0]        LFSR_SEED  = 16'hACE1;
  localparam logic [9:0]         X_OFFSET   = 10'd16;
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [7:0]         KEY_START  = 8'h28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_lives, w_lives_nxt;
  logic [15:0]          r_score, w_score_nxt;
  logic [SPAWN_W-1:0]   r_spawn_cnt, w_spawn_cnt_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt, w_hold_cnt_nxt;
  logic [1:0]           r_last_slot, w_last_slot_nxt;
  logic [3:0]           r_spawn_req, w_spawn_req_nxt;
  logic [9:0]           r_spawn_x, w_spawn_x_nxt;
  logic                 r_ball_reset, w_ball_reset_nxt;
  logic [15:0]          r_lfsr;
  logic                 r_key_prev;
  logic                 r_armed;

  logic                 w_key_hit;
  logic                 w_start;
  logic                 w_unused_key;
  logic                 w_lfsr_fb;
  logic                 w_spawn_term;
  logic                 w_free_found;
  logic [1:0]           w_free_slot;
  logic [1:0]           w_probe;

  // Start key detection. r_armed stays low after reset until a frame with
  // no start key is seen, so a key held through reset release cannot start
  // a game; the player has to release and press again.
  assign w_key_hit = (bus.keycode[7:0]   == KEY_START) ||
                     (bus.keycode[15:8]  == KEY_START) ||
                     (bus.keycode[23:16] == KEY_START);
  assign w_start      = w_key_hit && !r_key_prev && r_armed;
  assign w_unused_key = bus.keycode[24];

  // Fibonacci LFSR, taps 16,14,13,11 (maximal length, never reaches zero).
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_spawn_term = (r_spawn_cnt == SPAWN_TC);

  // Round-robin search: first free slot starting just after the last one
  // used. The fourth probe wraps back onto last_slot itself.
  always_comb begin
    w_free_found = 1'b0;
    w_free_slot  = r_last_slot;
    w_probe      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_probe = r_last_slot + 2'(i);
      if (!w_free_found && !bus.enemy_alive[w_probe]) begin
        w_free_found = 1'b1;
        w_free_slot  = w_probe;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_spawn_cnt_nxt  = r_spawn_cnt;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_last_slot_nxt  = r_last_slot;
    w_spawn_req_nxt  = 4'b0000;
    w_spawn_x_nxt    = r_spawn_x;
    w_ball_reset_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt      = ST_PLAY;
          w_lives_nxt      = LIVES_LOAD;
          w_score_nxt      = 16'd0;
          w_spawn_cnt_nxt  = '0;
          w_ball_reset_nxt = 1'b1;
        end
      end

      ST_PLAY: begin
        if (r_score != 16'hFFFF) begin
          w_score_nxt = r_score + 16'd1;
        end

        // At terminal count the counter parks until a spawn succeeds; a
        // collision in the same frame suppresses the spawn and the wrap.
        if (!w_spawn_term) begin
          w_spawn_cnt_nxt = r_spawn_cnt + SPAWN_W'(1);
        end else if (!bus.Ball_die && w_free_found) begin
          w_spawn_req_nxt = 4'b0001 << w_free_slot;
          w_last_slot_nxt = w_free_slot;
          w_spawn_cnt_nxt = '0;
          w_spawn_x_nxt   = X_OFFSET + {1'b0, r_lfsr[8:0]};
        end

        if (bus.Ball_die) begin
          w_state_nxt    = ST_DYING;
          w_lives_nxt    = r_lives - 2'd1;
          w_hold_cnt_nxt = '0;
        end
      end

      ST_DYING: begin
        if (r_hold_cnt == HOLD_TC) begin
          if (r_lives == 2'd0) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt      = ST_PLAY;
            w_ball_reset_nxt = 1'b1;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end

      ST_OVER: begin
        if (w_start) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_lives      <= 2'd0;
      r_score      <= 16'd0;
      r_spawn_cnt  <= '0;
      r_hold_cnt   <= '0;
      r_last_slot  <= 2'd3;
      r_spawn_req  <= 4'b0000;
      r_spawn_x    <= X_OFFSET;
      r_ball_reset <= 1'b0;
      r_lfsr       <= LFSR_SEED;
      r_key_prev   <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_spawn_cnt  <= w_spawn_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_last_slot  <= w_last_slot_nxt;
      r_spawn_req  <= w_spawn_req_nxt;
      r_spawn_x    <= w_spawn_x_nxt;
      r_ball_reset <= w_ball_reset_nxt;
      r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
      r_key_prev   <= w_key_hit;
      r_armed      <= r_armed | ~w_key_hit;
    end
  end

  assign bus.game_state = r_state;
  assign bus.freeze     = (r_state != ST_PLAY);
  assign bus.spawn_req  = r_spawn_req;
  assign bus.spawn_x    = r_spawn_x;
  assign bus.ball_reset = r_ball_reset;
  assign bus.lives      = r_lives;
  assign bus.score      = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
  localparam int PER    = 60;
  localparam int HOLD   = 90;
  localparam int LIVES0 = 3;

  logic frame_clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  game_ctrl_if bus();

  game_ctrl #(.SPAWN_PERIOD(PER), .DIE_HOLD(HOLD), .LIVES_INIT(LIVES0)) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [24:0] kc;
    logic        die;
    logic [3:0]  alive;
    int          st;
    int          lives;
    int          br;
    int          score;
    int          req;
  } vec_t;

  vec_t vecs [10];

  // reference model state
  int          m_state, m_lives, m_score, m_since, m_die_left, m_last;
  int          m_req, m_x, m_br;
  logic [15:0] m_lfsr;
  bit          m_prev, m_need_release;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic drive(input logic [24:0] kc, input logic die, input logic [3:0] alive);
    bus.keycode  = kc;
    bus.Ball_die = die;
    for (int i = 0; i < 4; i++) bus.enemy_alive[i] = alive[i];
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, int'(bus.game_state), 0);
    chk({tag, "_lives"}, int'(bus.lives), 0);
    chk({tag, "_score"}, int'(bus.score), 0);
    chk({tag, "_req"},   int'(bus.spawn_req), 0);
    chk({tag, "_br"},    int'(bus.ball_reset), 0);
    chk({tag, "_x"},     int'(bus.spawn_x), 16);
    chk({tag, "_frz"},   int'(bus.freeze), 1);
  endtask

  task automatic apply_reset(input string tag);
    Reset = 1'b1;
    step();
    check_reset_vals(tag);
    Reset = 1'b0;
  endtask

  task automatic m_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_since = 0; m_die_left = 0;
    m_last = 3; m_req = 0; m_x = 16; m_br = 0; m_lfsr = 16'hACE1;
    m_prev = 0; m_need_release = 1;
  endtask

  // One frame of the game rules, applied to the inputs present before the edge.
  task automatic m_edge(input logic [24:0] kc, input logic die, input logic [3:0] alive);
    bit   hit, go;
    int   cand;
    int   q[$];
    hit = 0;
    for (int b = 0; b < 3; b++) if (kc[8*b +: 8] == 8'h28) hit = 1;
    go = hit && !m_prev && !m_need_release;
    m_prev = hit;
    if (!hit) m_need_release = 0;
    cand = 16 + int'(m_lfsr) % 512;
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    m_req = 0;
    m_br  = 0;
    case (m_state)
      0: if (go) begin
        m_state = 1; m_lives = LIVES0; m_score = 0; m_since = 0; m_br = 1;
      end
      1: begin
        if (m_score < 65535) m_score++;
        if (m_since < PER - 1) m_since++;
        else if (!die) begin
          for (int k = 1; k <= 4; k++)
            if (!alive[(m_last + k) % 4]) q.push_back((m_last + k) % 4);
          if (q.size() > 0) begin
            m_req = 1 << q[0]; m_last = q[0]; m_since = 0; m_x = cand;
          end
        end
        if (die) begin
          m_state = 2; m_lives--; m_die_left = HOLD;
        end
      end
      2: begin
        m_die_left--;
        if (m_die_left == 0) begin
          if (m_lives == 0) m_state = 3;
          else begin m_state = 1; m_br = 1; end
        end
      end
      default: if (go) m_state = 0;
    endcase
  endtask

  initial begin
    int          early, off, sc_death;
    logic [24:0] kc;
    logic        die;
    logic [3:0]  al;

    Reset = 1'b1;
    drive(25'h0, 1'b0, 4'h0);
    apply_reset("rst0");

    // ---------------- table-driven vectors ----------------
    vecs[0] = '{25'h0000000, 1'b0, 4'hF, 0, 0, 0, 0, 0};
    vecs[1] = '{25'h1000000, 1'b0, 4'hF, 0, 0, 0, 0, 0};
    vecs[2] = '{25'h0002800, 1'b0, 4'hF, 1, 3, 1, 0, 0};
    vecs[3] = '{25'h0002800, 1'b0, 4'hF, 1, 3, 0, 1, 0};
    vecs[4] = '{25'h0280000, 1'b0, 4'hF, 1, 3, 0, 2, 0};
    vecs[5] = '{25'h0000000, 1'b0, 4'hF, 1, 3, 0, 3, 0};
    vecs[6] = '{25'h0000028, 1'b0, 4'hF, 1, 3, 0, 4, 0};
    vecs[7] = '{25'h0000000, 1'b1, 4'hF, 2, 2, 0, 5, 0};
    vecs[8] = '{25'h0000028, 1'b1, 4'hF, 2, 2, 0, 5, 0};
    vecs[9] = '{25'h0000000, 1'b0, 4'hF, 2, 2, 0, 5, 0};
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].kc, vecs[v].die, vecs[v].alive);
      step();
      chk("vec_state", int'(bus.game_state), vecs[v].st);
      chk("vec_lives", int'(bus.lives), vecs[v].lives);
      chk("vec_br",    int'(bus.ball_reset), vecs[v].br);
      chk("vec_score", int'(bus.score), vecs[v].score);
      chk("vec_req",   int'(bus.spawn_req), vecs[v].req);
      chk("vec_frz",   int'(bus.freeze), (vecs[v].st != 1) ? 1 : 0);
    end

    // ---------------- start and spawn cadence ----------------
    apply_reset("rst1");
    drive(25'h0, 1'b0, 4'h0);
    step();
    drive(25'h000028, 1'b0, 4'h0);
    step();
    chk("start_state", int'(bus.game_state), 1);
    chk("start_lives", int'(bus.lives), 3);
    chk("start_score", int'(bus.score), 0);
    chk("start_br",    int'(bus.ball_reset), 1);
    chk("start_frz",   int'(bus.freeze), 0);
    drive(25'h0, 1'b0, 4'h0);
    step();
    chk("start_br_one", int'(bus.ball_reset), 0);
    early = 0;
    for (int n = 2; n < 60; n++) begin
      step();
      if (bus.spawn_req != 4'b0) early++;
    end
    step();
    chk("sp1_early", early, 0);
    chk("sp1_req",   int'(bus.spawn_req), 1);
    chk("sp1_x_rng", int'(bus.spawn_x >= 10'd16 && bus.spawn_x <= 10'd527), 1);
    chk("sp1_score", int'(bus.score), 60);
    early = 0;
    for (int n = 61; n < 120; n++) begin
      step();
      if (bus.spawn_req != 4'b0) early++;
    end
    step();
    chk("sp2_early", early, 0);
    chk("sp2_req",   int'(bus.spawn_req), 2);
    chk("sp2_x_rng", int'(bus.spawn_x >= 10'd16 && bus.spawn_x <= 10'd527), 1);

    // all slots busy across terminal count, then slot 2 frees
    drive(25'h0, 1'b0, 4'hF);
    early = 0;
    for (int n = 121; n <= 185; n++) begin
      step();
      if (bus.spawn_req != 4'b0) early++;
    end
    chk("full_nospawn", early, 0);
    drive(25'h0, 1'b0, 4'b1011);
    step();
    chk("full_slot2", int'(bus.spawn_req), 4);
    drive(25'h0, 1'b0, 4'hF);
    step();
    chk("full_slot2_one", int'(bus.spawn_req), 0);

    // collision on the terminal-count frame
    for (int n = 188; n <= 245; n++) step();
    drive(25'h0, 1'b1, 4'h0);
    step();
    chk("die_tc_req",   int'(bus.spawn_req), 0);
    chk("die_tc_state", int'(bus.game_state), 2);
    chk("die_tc_lives", int'(bus.lives), 2);
    drive(25'h0, 1'b0, 4'h0);
    off = 0;
    for (int n = 1; n < HOLD; n++) begin
      step();
      if (bus.game_state != 2'd2 || bus.ball_reset || bus.spawn_req != 4'b0) off++;
    end
    chk("die_hold", off, 0);
    step();
    chk("die_exit_state", int'(bus.game_state), 1);
    chk("die_exit_br",    int'(bus.ball_reset), 1);
    step();
    chk("die_retry_req", int'(bus.spawn_req), 8);
    chk("die_retry_br",  int'(bus.ball_reset), 0);

    // two more deaths -> game over
    drive(25'h0, 1'b1, 4'hF);
    step();
    chk("d2_lives", int'(bus.lives), 1);
    drive(25'h0, 1'b0, 4'hF);
    for (int n = 0; n < HOLD; n++) step();
    chk("d2_back", int'(bus.game_state), 1);
    drive(25'h0, 1'b1, 4'hF);
    step();
    chk("d3_lives", int'(bus.lives), 0);
    sc_death = int'(bus.score);
    drive(25'h0, 1'b0, 4'hF);
    for (int n = 0; n < HOLD; n++) step();
    chk("over_state", int'(bus.game_state), 3);
    chk("over_lives", int'(bus.lives), 0);
    chk("over_frz",   int'(bus.freeze), 1);
    for (int n = 0; n < 5; n++) step();
    chk("over_score", int'(bus.score), sc_death);
    drive(25'h000028, 1'b0, 4'hF);
    step();
    chk("over_to_idle", int'(bus.game_state), 0);
    drive(25'h0, 1'b0, 4'hF);
    step();
    drive(25'h002800, 1'b0, 4'hF);
    step();
    chk("restart_state", int'(bus.game_state), 1);
    chk("restart_score", int'(bus.score), 0);
    chk("restart_lives", int'(bus.lives), 3);

    // reset mid-DYING with the start key held through release
    drive(25'h0, 1'b0, 4'hF);
    step();
    drive(25'h0, 1'b1, 4'hF);
    step();
    drive(25'h0, 1'b0, 4'h0);
    for (int n = 0; n < 40; n++) step();
    chk("mid_die_state", int'(bus.game_state), 2);
    Reset = 1'b1;
    bus.keycode = 25'h000028;
    #1;
    check_reset_vals("async_rst");
    off = 0;
    for (int n = 0; n < 2; n++) begin
      step();
      if (bus.ball_reset || bus.spawn_req != 4'b0 || bus.game_state != 2'd0) off++;
    end
    Reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (bus.ball_reset || bus.spawn_req != 4'b0 || bus.game_state != 2'd0) off++;
    end
    chk("held_key_quiet", off, 0);
    drive(25'h0, 1'b0, 4'h0);
    step();
    chk("held_release", int'(bus.game_state), 0);
    drive(25'h000028, 1'b0, 4'h0);
    step();
    chk("held_repress", int'(bus.game_state), 1);
    chk("held_repress_br", int'(bus.ball_reset), 1);

    // ---------------- randomized run against the model ----------------
    apply_reset("rst2");
    m_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        Reset = 1'b1;
        #1;
        check_reset_vals("rnd_rst");
        m_reset();
        step();
        Reset = 1'b0;
      end else begin
        case ($urandom_range(0, 19))
          0, 1, 2:     kc = 25'($urandom);
          3, 4, 5, 6:  begin
            kc = 25'($urandom);
            kc[8 * $urandom_range(0, 2) +: 8] = 8'h28;
          end
          default:     kc = 25'h0;
        endcase
        die = ($urandom_range(0, 119) == 0);
        al  = 4'($urandom) | 4'($urandom);
        drive(kc, die, al);
        m_edge(kc, die, al);
        step();
        chk("rnd_state", int'(bus.game_state), m_state);
        chk("rnd_lives", int'(bus.lives), m_lives);
        chk("rnd_score", int'(bus.score), m_score);
        chk("rnd_req",   int'(bus.spawn_req), m_req);
        chk("rnd_x",     int'(bus.spawn_x), m_x);
        chk("rnd_br",    int'(bus.ball_reset), m_br);
        chk("rnd_frz",   int'(bus.freeze), (m_state != 1) ? 1 : 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SPAWN_PERIOD, default 60, frames between spawn attempts.
REQ-002 Parameter DIE_HOLD, default 90, frames the death freeze lasts.
REQ-003 Parameter LIVES_INIT, default 3, lives loaded at game start (range 1..3).
REQ-004 frame_clk  in  1  single clock, one rising edge per video frame.
REQ-005 Reset  in  1  asynchronous, active-high; the block SHALL use one clock with asynchronous active-high reset.
REQ-006 keycode  in  25  three packed USB keycodes in [7:0], [15:8] and [23:16]; bit 24 ignored.
REQ-007 Ball_die  in  1  player collision flag.
REQ-008 enemy_alive  in  4 x 1  per-slot occupancy, unpacked array [4].
REQ-009 game_state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER.
REQ-010 spawn_req  out  4 x 1  one-cycle, one-hot spawn command per slot.
REQ-011 spawn_x  out  10  X position for the spawned enemy, valid while any spawn_req is high.
REQ-012 ball_reset  out  1  one-cycle pulse that re-centres the player.
REQ-013 freeze  out  1  high when not in PLAY; stops enemy motion.
REQ-014 lives  out  2  remaining lives.
REQ-015 score  out  16  frames survived in the current game.

Function
REQ-016 start SHALL be the rising edge of "any keycode byte == 8'h28", registered against the previous frame's value.
REQ-017 IDLE->PLAY on start:
- lives<=LIVES_INIT
- score<=0
- spawn counter<=0
- ball_reset pulse.
REQ-018 PLAY->DYING on Ball_die=1; Ball_die is ignored in all other states.
REQ-019 DYING SHALL hold for exactly DIE_HOLD frames, counted by hold_cnt from 0, and SHALL decrement lives once, on entry.
REQ-020 On hold_cnt==DIE_HOLD-1:
- lives==0 -> OVER
- otherwise -> PLAY with a one-cycle ball_reset pulse.
REQ-021 OVER->IDLE on start; a second start is needed to begin PLAY.
REQ-022 Score increments by 1 each frame in PLAY, saturates at 16'hFFFF, and holds in the other states until the next game start.
REQ-023 Spawn counter:
- counts 0..SPAWN_PERIOD-1 only in PLAY and holds otherwise
- at terminal count, a spawn attempt is made.
REQ-024 Slot selection SHALL be round-robin: search for the first slot with enemy_alive=0, starting at last_slot+1 modulo 4. last_slot resets to 3, so slot 0 is searched first.
REQ-025 If a free slot exists:
- assert spawn_req for that slot for one cycle
- update last_slot
- counter wraps to 0.
REQ-026 If all four slots are alive, no spawn occurs; the counter holds at terminal and retries every frame.
REQ-027 spawn_x = 16 + lfsr[8:0], range 16..527.
REQ-028 lfsr is a 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1. It advances every frame and is never all-zero.
REQ-029 If Ball_die and a spawn attempt occur in the same frame, Ball_die wins: no spawn_req, and the counter does not wrap.
REQ-030 At most one spawn_req bit SHALL be high in any cycle; all spawn_req bits are 0 outside PLAY.
REQ-031 freeze = (game_state != PLAY), decoded combinationally from the state register.
REQ-032 All other outputs SHALL be registered.

Reset
REQ-033 On Reset, the following SHALL take effect immediately:
- game_state=IDLE
- lives=0
- score=0
- spawn_req=0
- ball_reset=0
- spawn_x=16
- lfsr=16'hACE1
- counters=0
- last_slot=3
- start history=0.
REQ-034 Reset in any state, including mid-DYING, SHALL abort the game with no spawn or ball_reset pulse emitted. After release, start is needed to play.

Verification
REQ-035 Reset, then keycode=25'h000028 for one frame -> next cycle game_state=1, lives=3, score=0, ball_reset=1 for one cycle.
REQ-036 PLAY with all enemy_alive=0 for 60 frames -> spawn_req=4'b0001 on frame 60, then 4'b0010 on frame 120; spawn_x in 16..527.
REQ-037 All enemy_alive=1 across terminal count, then slot 2 clears -> spawn_req=4'b0100 on the next frame, with no frame delay beyond it.
REQ-038 Ball_die=1 in the terminal-count frame -> no spawn_req; game_state=2 and lives=2. After 90 frames -> game_state=1 with a ball_reset pulse.
REQ-039 Three deaths -> game_state=3 with lives=0 and score frozen. Start -> IDLE; start again -> PLAY with score=0.
REQ-040 Reset asserted mid-DYING (hold_cnt=40) -> immediate IDLE, lives=0, no pulses emitted. Key 8'h28 held through reset release -> no start until the key is released and pressed again.
